// File: rtl/hv_am_classifier.sv
// Hamming-distance associative memory: finds the nearest class prototype to a query HV, one chunk per cycle.
// Optional HV_AM_DIST_OUT_EN adds the all_dist output with every class's final distance.
module hv_am_classifier #(
    parameter int DIMENSIONS  = 10000,
    parameter int NUM_CLASSES = 2,
    parameter int CHUNK_WIDTH = 500
) (
    input  logic                                               clk,
    input  logic                                               nrst,
    input  logic                                               en,
    input  logic [DIMENSIONS-1:0]                              window_hv,
    input  logic                                               wr_en,
    input  logic [(NUM_CLASSES > 1 ? $clog2(NUM_CLASSES) : 1)-1:0] wr_class,
    input  logic [DIMENSIONS-1:0]                              wr_hv,
    output logic                                               busy,
    output logic                                               done,
    output logic [(NUM_CLASSES > 1 ? $clog2(NUM_CLASSES) : 1)-1:0] label,
    output logic [$clog2(DIMENSIONS+1)-1:0]                    min_dist
`ifdef HV_AM_DIST_OUT_EN
    ,
    output logic [NUM_CLASSES-1:0][$clog2(DIMENSIONS+1)-1:0]   all_dist
`endif
);

    // state     | meaning
    // S_IDLE    | waiting for en; prototype writes accepted
    // S_COMPUTE | accumulating one chunk distance per cycle, class by class
    // S_RESULT  | publishing the winner and pulsing done

    localparam int CW   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int DW   = $clog2(DIMENSIONS + 1);
    localparam int NCH  = DIMENSIONS / CHUNK_WIDTH;
    localparam int NCHW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [NCHW-1:0] LAST_CHUNK = NCHW'(NCH - 1);
    localparam logic [CW-1:0]   LAST_CLASS = CW'(NUM_CLASSES - 1);

    generate
        if (DIMENSIONS % CHUNK_WIDTH != 0) begin : g_bad_chunk
            $error("hv_am_classifier: DIMENSIONS must be a multiple of CHUNK_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_RESULT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DIMENSIONS-1:0]   query_q, query_d;
    logic [DIMENSIONS-1:0]   proto_q [NUM_CLASSES];
    logic [DIMENSIONS-1:0]   proto_d [NUM_CLASSES];
    logic [DW-1:0]           acc_q, acc_d;
    logic [NCHW-1:0]         chunk_q, chunk_d;
    logic [CW-1:0]           class_q, class_d;
    logic [DW-1:0]           best_dist_q, best_dist_d;
    logic [CW-1:0]           best_label_q, best_label_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic [CW-1:0]           label_q, label_d;
    logic [DW-1:0]           min_dist_q, min_dist_d;
`ifdef HV_AM_DIST_OUT_EN
    logic [NUM_CLASSES-1:0][DW-1:0] all_dist_q, all_dist_d;
`endif

    logic [NCH-1:0][CHUNK_WIDTH-1:0] q_chunks;
    logic [NCH-1:0][CHUNK_WIDTH-1:0] p_chunks;
    logic [CHUNK_WIDTH-1:0]          chunk_diff;
    logic [DW-1:0]                   chunk_dist;
    logic [DW-1:0]                   total;

    always_comb begin
        q_chunks   = query_q;
        p_chunks   = proto_q[class_q];
        chunk_diff = q_chunks[chunk_q] ^ p_chunks[chunk_q];
        chunk_dist = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            chunk_dist = chunk_dist + DW'(chunk_diff[i]);
        end
        total = acc_q + chunk_dist;
    end

    always_comb begin
        state_d      = state_q;
        query_d      = query_q;
        proto_d      = proto_q;
        acc_d        = acc_q;
        chunk_d      = chunk_q;
        class_d      = class_q;
        best_dist_d  = best_dist_q;
        best_label_d = best_label_q;
        done_d       = done_q;
        busy_d       = busy_q;
        label_d      = label_q;
        min_dist_d   = min_dist_q;
`ifdef HV_AM_DIST_OUT_EN
        all_dist_d   = all_dist_q;
`endif

        case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                // A write in the same cycle as en lands before the first chunk is read.
                if (wr_en && (int'(wr_class) < NUM_CLASSES)) begin
                    proto_d[wr_class] = wr_hv;
                end
                if (en) begin
                    query_d = window_hv;
                    class_d = '0;
                    chunk_d = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (chunk_q != LAST_CHUNK) begin
                    acc_d   = total;
                    chunk_d = chunk_q + 1'b1;
                end else begin
                    // Strict less-than keeps ties on the lower class index.
                    if ((class_q == '0) || (total < best_dist_q)) begin
                        best_dist_d  = total;
                        best_label_d = class_q;
                    end
`ifdef HV_AM_DIST_OUT_EN
                    all_dist_d[class_q] = total;
`endif
                    chunk_d = '0;
                    acc_d   = '0;
                    if (class_q == LAST_CLASS) begin
                        state_d = S_RESULT;
                    end else begin
                        class_d = class_q + 1'b1;
                    end
                end
            end
            S_RESULT: begin
                label_d    = best_label_q;
                min_dist_d = best_dist_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            query_q      <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                proto_q[c] <= '0;
            end
            acc_q        <= '0;
            chunk_q      <= '0;
            class_q      <= '0;
            best_dist_q  <= '0;
            best_label_q <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            label_q      <= '0;
            min_dist_q   <= '0;
`ifdef HV_AM_DIST_OUT_EN
            all_dist_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            query_q      <= query_d;
            proto_q      <= proto_d;
            acc_q        <= acc_d;
            chunk_q      <= chunk_d;
            class_q      <= class_d;
            best_dist_q  <= best_dist_d;
            best_label_q <= best_label_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            label_q      <= label_d;
            min_dist_q   <= min_dist_d;
`ifdef HV_AM_DIST_OUT_EN
            all_dist_q   <= all_dist_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign label    = label_q;
    assign min_dist = min_dist_q;
`ifdef HV_AM_DIST_OUT_EN
    assign all_dist = all_dist_q;
`endif

endmodule

// File: tb/tb_hv_am_classifier.sv
// Directed bench for hv_am_classifier at DIMENSIONS=64, CHUNK_WIDTH=16, NUM_CLASSES=2.
module tb_hv_am_classifier;

    localparam int D   = 64;
    localparam int NC  = 2;
    localparam int CWD = 16;
    localparam int DW  = 7;
    localparam int LAT = NC * (D / CWD) + 1;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          en = 1'b0;
    logic [D-1:0]  window_hv = '0;
    logic          wr_en = 1'b0;
    logic [0:0]    wr_class = '0;
    logic [D-1:0]  wr_hv = '0;
    logic          busy;
    logic          done;
    logic [0:0]    label;
    logic [DW-1:0] min_dist;
`ifdef HV_AM_DIST_OUT_EN
    logic [NC-1:0][DW-1:0] all_dist;
`endif

    int checks = 0;
    int errors = 0;

    hv_am_classifier #(
        .DIMENSIONS (D),
        .NUM_CLASSES(NC),
        .CHUNK_WIDTH(CWD)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en),
        .window_hv(window_hv),
        .wr_en    (wr_en),
        .wr_class (wr_class),
        .wr_hv    (wr_hv),
        .busy     (busy),
        .done     (done),
        .label    (label),
        .min_dist (min_dist)
`ifdef HV_AM_DIST_OUT_EN
        ,
        .all_dist (all_dist)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [D-1:0] p0;
        logic [D-1:0] p1;
        logic [D-1:0] win;
        int           exp_label;
        int           exp_d0;
        int           exp_d1;
        int           exp_dist;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic write_proto(input int cls, input logic [D-1:0] hv);
        wr_en    = 1'b1;
        wr_class = cls[0:0];
        wr_hv    = hv;
        @(negedge clk);
        wr_en    = 1'b0;
    endtask

    // Returns the number of rising edges after the en edge until done is seen (0 = timeout).
    task automatic run_query(input string tag, input logic [D-1:0] w, output int lat);
        en        = 1'b1;
        window_hv = w;
        @(negedge clk);
        en  = 1'b0;
        lat = 0;
        check({tag, " busy_after_en"}, busy, 1);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == LAT - 1) check({tag, " busy_before_done"}, busy, 1);
            if (done) begin
                lat = n;
                break;
            end
        end
        check({tag, " latency"}, lat, LAT);
        check({tag, " busy_at_done"}, busy, 0);
    endtask

    initial begin
        int lat;
        int done_cnt;

        vecs[0] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_00FF, 0, 8, 56, 8};
        vecs[1] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FF00, 1, 56, 8, 8};
        vecs[2] = '{64'h0F, 64'hF0, 64'h00, 0, 4, 4, 4};
        vecs[3] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAB, 0, 1, 63, 1};
        vecs[4] = '{64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 64'h0000_FFFF_0000_FFFF, 1, 64, 0, 0};
        vecs[5] = '{64'h1234, 64'h1234, 64'h0, 0, 5, 5, 5};

        repeat (2) @(negedge clk);
        check("reset done", done, 0);
        check("reset busy", busy, 0);
        check("reset label", label, 0);
        check("reset min_dist", min_dist, 0);
`ifdef HV_AM_DIST_OUT_EN
        check("reset all_dist", all_dist, 0);
`endif
        nrst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            write_proto(0, vecs[v].p0);
            write_proto(1, vecs[v].p1);
            run_query(tag, vecs[v].win, lat);
            check({tag, " label"}, label, vecs[v].exp_label);
            check({tag, " min_dist"}, min_dist, vecs[v].exp_dist);
`ifdef HV_AM_DIST_OUT_EN
            check({tag, " all_dist0"}, all_dist[0], vecs[v].exp_d0);
            check({tag, " all_dist1"}, all_dist[1], vecs[v].exp_d1);
`endif
            @(negedge clk);
            check({tag, " done_one_cycle"}, done, 0);
            check({tag, " label_held"}, label, vecs[v].exp_label);
        end

        // en and a proto1 write arriving mid-run must both be dropped.
        write_proto(0, 64'h0);
        write_proto(1, 64'hFFFF_FFFF_FFFF_FFFF);
        en        = 1'b1;
        window_hv = 64'h0000_0000_0000_00FF;
        @(negedge clk);
        en = 1'b0;
        done_cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n == 3) begin
                en        = 1'b1;
                window_hv = 64'hFFFF_FFFF_FFFF_FFFF;
                wr_en     = 1'b1;
                wr_class  = 1'b1;
                wr_hv     = 64'h0;
            end
            @(negedge clk);
            en    = 1'b0;
            wr_en = 1'b0;
            if (done) begin
                done_cnt++;
                check("busy_ign latency", n, LAT);
                check("busy_ign label", label, 0);
                check("busy_ign min_dist", min_dist, 8);
            end
        end
        check("busy_ign done_count", done_cnt, 1);
        run_query("proto1_kept", 64'hFFFF_FFFF_FFFF_FF00, lat);
        check("proto1_kept label", label, 1);
        check("proto1_kept min_dist", min_dist, 8);
        @(negedge clk);

        // Reset during cycle 5 of a run aborts it and clears the prototypes.
        en        = 1'b1;
        window_hv = 64'h0000_0000_0000_00FF;
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        nrst = 1'b0;
        #1;
        check("midrst done", done, 0);
        check("midrst busy", busy, 0);
        check("midrst label", label, 0);
        check("midrst min_dist", min_dist, 0);
        @(negedge clk);
        nrst = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midrst no_done", done_cnt, 0);
        run_query("post_rst", 64'h00F0_0000_0000_1001, lat);
        check("post_rst label", label, 0);
        check("post_rst min_dist", min_dist, 6);
        @(negedge clk);

        // Write and en together: the query must see the freshly written proto1.
        wr_en     = 1'b1;
        wr_class  = 1'b1;
        wr_hv     = 64'h0123_4567_89AB_CDEF;
        run_query("wr_en_same", 64'h0123_4567_89AB_CDEF, lat);
        check("wr_en_same label", label, 1);
        check("wr_en_same min_dist", min_dist, 0);
`ifdef HV_AM_DIST_OUT_EN
        check("wr_en_same all_dist0", all_dist[0], 32);
`endif
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // run_query drops wr_en one cycle after it was raised for the simultaneous case.
    always @(negedge clk) begin
        if (wr_en && busy) wr_en = 1'b0;
    end

endmodule
